// File: rtl/bypass_fifo_n_pkg.sv
// Shared sizing helpers for the bypass FIFO and its pointer sub-module.
package bypass_fifo_n_pkg;

  localparam int MIN_PTR_W = 1;

  // Constant-evaluated ceil(log2(value)); clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  function automatic int ptr_width(input int depth);
    return (clog2(depth) < MIN_PTR_W) ? MIN_PTR_W : clog2(depth);
  endfunction

endpackage

// File: rtl/bypass_fifo_n_ptr_wrap.sv
// Circular-buffer pointer: increments modulo DEPTH with an explicit wrap,
// so DEPTH need not be a power of two.
module fifo_ptr_wrap
  import bypass_fifo_n_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // NOTE: ptr_d is assigned its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/bypass_fifo_n.sv
// DEPTH-entry FIFO with optional empty-bypass, occupancy count, sticky
// overflow/underflow flags and per-round consumed tracking.
module bypass_fifo_n
  import bypass_fifo_n_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int DEPTH  = 2,
  parameter int BYPASS = 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        ENQ,
  input  logic [WIDTH-1:0]            ENQ_VALUE,
  output logic                        NOT_FULL,
  input  logic                        DEQ,
  output logic [WIDTH-1:0]            DEQ_VALUE,
  output logic                        NOT_EMPTY,
  output logic [clog2(DEPTH+1)-1:0]   COUNT,
  input  logic                        RESET,
  output logic                        CONSUMED_BEFORE,
  output logic                        CONSUMED,
  output logic                        OVERFLOW,
  output logic                        UNDERFLOW
);

  localparam int               CNT_W    = clog2(DEPTH + 1);
  localparam int               PTR_W    = ptr_width(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam bit               BYP      = (BYPASS != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_q, count_d;
  logic             consumed_q, consumed_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             empty, full, not_empty;
  logic             enq_ok, deq_ok, pass, wr, rd;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_CNT);
    not_empty = !empty || (BYP && ENQ);
    enq_ok    = ENQ && !full;
    deq_ok    = DEQ && not_empty;
    // An empty bypass FIFO hands ENQ_VALUE straight through without storing it.
    pass      = BYP && empty && enq_ok && deq_ok;
    wr        = enq_ok && !pass;
    rd        = deq_ok && !pass;

    count_d = count_q;
    if (wr && !rd)      count_d = count_q + CNT_W'(1);
    else if (rd && !wr) count_d = count_q - CNT_W'(1);

    consumed_d  = RESET ? 1'b0 : (ENQ ? 1'b1 : consumed_q);
    overflow_d  = overflow_q  || (ENQ && full);
    underflow_d = underflow_q || (DEQ && !not_empty);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q     <= '0;
      consumed_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      consumed_q  <= consumed_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; COUNT alone decides validity, so stale entries are never observed.
  always_ff @(posedge CLK) begin
    if (wr) mem_q[tail] <= ENQ_VALUE;
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_head (
    .clk (CLK),
    .rst (RST),
    .inc (rd),
    .ptr (head)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_tail (
    .clk (CLK),
    .rst (RST),
    .inc (wr),
    .ptr (tail)
  );

  assign NOT_FULL        = !full;
  assign NOT_EMPTY       = not_empty;
  assign DEQ_VALUE       = (BYP && empty) ? ENQ_VALUE : mem_q[head];
  assign COUNT           = count_q;
  assign CONSUMED_BEFORE = consumed_q;
  assign CONSUMED        = ENQ || consumed_q;
  assign OVERFLOW        = overflow_q;
  assign UNDERFLOW       = underflow_q;

endmodule

// File: tb/tb_bypass_fifo_n.sv
// Drives a bypass (DEPTH=4) and a registered (DEPTH=3) FIFO with shared
// stimulus; a queue-based model feeds a scoreboard checked at each negedge.
module tb_bypass_fifo_n;

  logic       clk = 1'b0;
  logic       rst, enq, deq, round_rst;
  logic [7:0] enq_value;
  logic [1:0] nf, ne, cons, consb, ovf, udf;
  logic [7:0] dv0, dv1;
  logic [2:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  bypass_fifo_n #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) dut0 (
    .CLK(clk), .RST(rst), .ENQ(enq), .ENQ_VALUE(enq_value), .NOT_FULL(nf[0]),
    .DEQ(deq), .DEQ_VALUE(dv0), .NOT_EMPTY(ne[0]), .COUNT(cnt0), .RESET(round_rst),
    .CONSUMED_BEFORE(consb[0]), .CONSUMED(cons[0]), .OVERFLOW(ovf[0]), .UNDERFLOW(udf[0])
  );

  bypass_fifo_n #(.WIDTH(8), .DEPTH(3), .BYPASS(0)) dut1 (
    .CLK(clk), .RST(rst), .ENQ(enq), .ENQ_VALUE(enq_value), .NOT_FULL(nf[1]),
    .DEQ(deq), .DEQ_VALUE(dv1), .NOT_EMPTY(ne[1]), .COUNT(cnt1), .RESET(round_rst),
    .CONSUMED_BEFORE(consb[1]), .CONSUMED(cons[1]), .OVERFLOW(ovf[1]), .UNDERFLOW(udf[1])
  );

  typedef struct {
    int         k;
    int         cyc;
    logic       ne;
    logic [7:0] dv;
    logic       nf;
    int         cnt;
    logic       cons;
    logic       consb;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mq [2][$];
  bit         m_cons [2];
  bit         m_ovf  [2];
  bit         m_udf  [2];
  int         checks   = 0;
  int         failures = 0;
  int         cycle    = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic bit byp(input int k);
    return (k == 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs and queue the outputs the model predicts for it.
  task automatic issue(input logic e, input logic [7:0] v, input logic d, input logic r);
    exp_t x;
    int   n;
    enq = e; enq_value = v; deq = d; round_rst = r;
    for (int k = 0; k < 2; k++) begin
      n       = mq[k].size();
      x.k     = k;
      x.cyc   = cycle;
      x.ne    = (n != 0) || (byp(k) && e);
      x.dv    = (n == 0) ? v : mq[k][0];
      x.nf    = (n != dep(k));
      x.cnt   = n;
      x.cons  = e || m_cons[k];
      x.consb = m_cons[k];
      x.ovf   = m_ovf[k];
      x.udf   = m_udf[k];
      expq.push_back(x);
    end
  endtask

  // Advance through the rising edge and apply the FIFO rules to the model.
  task automatic tick();
    int n;
    bit m_ne;
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        n    = mq[k].size();
        m_ne = (n != 0) || (byp(k) && enq);
        if (enq && n == dep(k)) m_ovf[k] = 1'b1;
        if (deq && !m_ne)       m_udf[k] = 1'b1;
        if (!(byp(k) && n == 0 && enq && deq)) begin
          if (deq && m_ne)          void'(mq[k].pop_front());
          if (enq && n != dep(k))   mq[k].push_back(enq_value);
        end
        if (round_rst) m_cons[k] = 1'b0;
        else if (enq)  m_cons[k] = 1'b1;
      end
    end
    cycle++;
    #1;
  endtask

  task automatic cyc(input logic e, input logic [7:0] v, input logic d, input logic r);
    issue(e, v, d, r);
    tick();
  endtask

  // Assert RST mid-cycle: contents must vanish before any clock edge.
  task automatic do_reset();
    rst = 1'b1; enq = 1'b0; deq = 1'b0; round_rst = 1'b0;
    #1;
    check("async_rst count0", 32'(cnt0), 0);
    check("async_rst count1", 32'(cnt1), 0);
    check("async_rst not_empty", 32'(ne), 0);
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_cons[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
    end
    issue(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t       x;
    logic       a_ne, a_nf, a_cons, a_consb, a_ovf, a_udf;
    logic [7:0] a_dv;
    int         a_cnt;
    string      tag;
    while (expq.size() > 0) begin
      x       = expq.pop_front();
      a_ne    = ne[x.k];    a_nf  = nf[x.k];  a_cons = cons[x.k];
      a_consb = consb[x.k]; a_ovf = ovf[x.k]; a_udf  = udf[x.k];
      a_dv    = (x.k == 0) ? dv0 : dv1;
      a_cnt   = (x.k == 0) ? int'(cnt0) : int'(cnt1);
      tag     = $sformatf("c%0d dut%0d", x.cyc, x.k);
      check({tag, " not_empty"}, 32'(a_ne), 32'(x.ne));
      check({tag, " not_full"}, 32'(a_nf), 32'(x.nf));
      check({tag, " count"}, a_cnt, x.cnt);
      check({tag, " consumed"}, 32'(a_cons), 32'(x.cons));
      check({tag, " consumed_before"}, 32'(a_consb), 32'(x.consb));
      check({tag, " overflow"}, 32'(a_ovf), 32'(x.ovf));
      check({tag, " underflow"}, 32'(a_udf), 32'(x.udf));
      if (x.ne) check({tag, " deq_value"}, 32'(a_dv), 32'(x.dv));
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enq = 1'b0; deq = 1'b0; round_rst = 1'b0; enq_value = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    issue(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("reset not_full", 32'(nf), 32'b11);
    check("reset count0", 32'(cnt0), 0);
    check("reset flags", 32'({ovf, udf, consb}), 0);
    tick();

    // Fill, then drain across the pointer wrap of the DEPTH=3 instance
    cyc(1'b1, 8'd1, 1'b0, 1'b0);
    cyc(1'b1, 8'd2, 1'b0, 1'b0);
    cyc(1'b1, 8'd3, 1'b0, 1'b0);
    check("fill not_full1", 32'(nf[1]), 0);
    check("fill count1", 32'(cnt1), 3);
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("wrap deq1 a", 32'(dv1), 1); tick();
    cyc(1'b1, 8'd4, 1'b0, 1'b0);
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("wrap deq1 b", 32'(dv1), 2); tick();
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("wrap deq1 c", 32'(dv1), 3); tick();
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("wrap deq1 d", 32'(dv1), 4); tick();
    check("wrap count1 end", 32'(cnt1), 0);

    // Simultaneous ENQ+DEQ at COUNT=2
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    issue(1'b1, 8'h33, 1'b1, 1'b0); #1; check("simul head", 32'(dv1), 32'h11); tick();
    check("simul count0", 32'(cnt0), 2);
    check("simul count1", 32'(cnt1), 2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("simul tail", 32'(dv1), 32'h33); tick();

    // Overflow on the DEPTH=3 instance, then underflow on both
    cyc(1'b1, 8'h0a, 1'b0, 1'b0);
    cyc(1'b1, 8'h0b, 1'b0, 1'b0);
    cyc(1'b1, 8'h0c, 1'b0, 1'b0);
    cyc(1'b1, 8'h07, 1'b0, 1'b0);
    check("ovf flag1", 32'(ovf[1]), 1);
    check("ovf count1", 32'(cnt1), 3);
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("ovf keep a", 32'(dv1), 32'h0a); tick();
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("ovf keep b", 32'(dv1), 32'h0b); tick();
    issue(1'b0, 8'h00, 1'b1, 1'b0); #1; check("ovf keep c", 32'(dv1), 32'h0c); tick();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("udf sticky", 32'(udf), 32'b11);
    check("ovf sticky", 32'(ovf), 32'b10);
    check("udf count0", 32'(cnt0), 0);

    // Reset mid-stream with COUNT=3, then bypass on an empty FIFO
    cyc(1'b1, 8'h21, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    cyc(1'b1, 8'h23, 1'b0, 1'b0);
    check("pre-rst count0", 32'(cnt0), 3);
    do_reset();
    check("post-rst flags", 32'({ovf, udf}), 0);
    issue(1'b1, 8'ha5, 1'b1, 1'b0);
    #1;
    check("bypass value", 32'(dv0), 32'ha5);
    check("bypass not_empty", 32'(ne[0]), 1);
    tick();
    check("bypass count0", 32'(cnt0), 0);

    // Registered path: data appears one cycle after enqueue
    do_reset();
    issue(1'b1, 8'h3c, 1'b0, 1'b0); #1; check("reg ne same cycle", 32'(ne[1]), 0); tick();
    issue(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    check("reg ne next", 32'(ne[1]), 1);
    check("reg value next", 32'(dv1), 32'h3c);
    tick();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Consumed tracking
    do_reset();
    issue(1'b1, 8'h55, 1'b0, 1'b0); #1; check("cons c0", 32'(cons), 32'b11); tick();
    issue(1'b0, 8'h00, 1'b0, 1'b0); #1; check("consb c1", 32'(consb), 32'b11); tick();
    issue(1'b1, 8'h66, 1'b0, 1'b1); #1; check("cons c2", 32'(cons), 32'b11); tick();
    check("consb c3", 32'(consb), 0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional mid-stream resets
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      else cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
               $urandom_range(0, 9) == 0);
    end

    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bypass_fifo_n.md
Name: bypass_fifo_n

Overview:
- Parametrised successor to the single-entry bypass FIFO used between latency-insensitive partitions of the multi-FPGA channel layer.
- Provides DEPTH entries of WIDTH-bit data.
- Optional combinational bypass when empty (BYPASS=1) or a strictly registered path (BYPASS=0).
- Keeps the per-round CONSUMED tracking and adds an occupancy count and sticky overflow/underflow error flags.

Parameters:
- WIDTH, 1: data bits per entry (≥1).
- DEPTH, 2: number of storage entries (≥1; need not be a power of two).
- BYPASS, 1: 1 = ENQ_VALUE visible on DEQ_VALUE in the same cycle when empty; 0 = data visible the cycle after enqueue.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- ENQ  in  1  enqueue strobe; legal only when NOT_FULL=1.
- ENQ_VALUE  in  WIDTH  enqueue data.
- NOT_FULL  out  1  COUNT < DEPTH.
- DEQ  in  1  dequeue strobe; legal only when NOT_EMPTY=1.
- DEQ_VALUE  out  WIDTH  head data.
- NOT_EMPTY  out  1  head data valid.
- COUNT  out  $clog2(DEPTH+1)  stored entries, excluding any same-cycle bypass.
- RESET  in  1  round clear for the consumed flag. This is not a hardware reset.
- CONSUMED_BEFORE  out  1  registered consumed flag.
- CONSUMED  out  1  ENQ || consumed flag.
- OVERFLOW  out  1  sticky: ENQ seen while full.
- UNDERFLOW  out  1  sticky: DEQ seen while NOT_EMPTY=0.

Behaviour:
- Reset
  - One clock; RST is asynchronous and active-high.
  - While RST=1: head/tail pointers=0, COUNT=0, consumed=0, OVERFLOW=0, UNDERFLOW=0.
  - Resulting outputs: NOT_FULL=1, NOT_EMPTY=ENQ if BYPASS else 0, CONSUMED=ENQ, CONSUMED_BEFORE=0.
  - Storage array is not reset. DEQ_VALUE is don't-care while NOT_EMPTY=0.
  - RST asserted mid-operation discards all contents immediately, with no wait for a clock edge.
- Storage
  - Circular buffer of DEPTH entries.
  - Pointers wrap explicitly from DEPTH-1 to 0, with no reliance on power-of-two overflow.
  - COUNT is a separate counter and is the sole full/empty source.
- Outputs
  - NOT_FULL = (COUNT != DEPTH).
  - BYPASS=1: NOT_EMPTY = (COUNT != 0) || ENQ; DEQ_VALUE = (COUNT==0) ? ENQ_VALUE : mem[head].
  - BYPASS=0: NOT_EMPTY = (COUNT != 0); DEQ_VALUE = mem[head].
- Legal-operation updates, per rising edge
  - ENQ only: write mem[tail], tail++, COUNT+1.
  - DEQ only: head++, COUNT-1.
  - ENQ and DEQ with COUNT>0: write and read both proceed; COUNT unchanged.
  - ENQ and DEQ with COUNT==0, BYPASS=1: data passes through. No write, pointers and COUNT unchanged.
  - ENQ and DEQ with COUNT==0, BYPASS=0: DEQ is illegal and is treated as below; the ENQ is stored.
  - Full FIFO: ENQ+DEQ in the same cycle is illegal. NOT_FULL is not relaxed by a same-cycle DEQ.
- Illegal operations
  - ENQ while COUNT==DEPTH: write dropped, state unchanged, OVERFLOW←1.
  - DEQ while NOT_EMPTY=0: ignored, UNDERFLOW←1.
  - Both flags are sticky until RST.
  - An illegal strobe never corrupts pointers or COUNT; the other, legal strobe in the same cycle still takes effect.
- Consumed tracking
  - Per edge: if RESET, consumed←0; else if ENQ, consumed←1. RESET has priority over a simultaneous ENQ.
  - A dropped (overflow) ENQ still counts as consumed.
  - CONSUMED is combinational: ENQ || consumed.
- Latency
  - BYPASS=1: 0 cycles when empty, otherwise FIFO order.
  - BYPASS=0: 1 cycle minimum.
  - Throughput 1 entry/cycle in both modes.
- DEPTH=1, BYPASS=1 is cycle-equivalent to the existing single-entry block, apart from the reset style and the added outputs.

Decomposition:
- Shared package: function clog2 for COUNT/pointer widths; a localparam for the pointer width (max(1, clog2(DEPTH))).
- One natural sub-module: fifo_ptr_wrap (pointer register with explicit modulo-DEPTH increment, async reset), instantiated for head and tail.
- Storage and flags stay inline.

Test Plan:
- Reset/bypass (WIDTH=8, DEPTH=4, BYPASS=1)
  - Stimulus: pulse RST mid-stream with COUNT=3; then ENQ=1, ENQ_VALUE=0xA5, DEQ=1 on an empty FIFO.
  - Required: COUNT=0 immediately at RST assertion, with no clock edge needed. Same cycle: DEQ_VALUE=0xA5, NOT_EMPTY=1. After the edge: COUNT=0.
- Fill/wrap (DEPTH=3)
  - Stimulus: ENQ 1,2,3 → NOT_FULL=0, COUNT=3. Then DEQ, ENQ 4, DEQ×3.
  - Required: DEQ_VALUE sequence 1,2,3,4; tail wraps to 0 then 1; COUNT ends 0.
- Overflow/underflow
  - Stimulus: ENQ 0x7 while full; separately, DEQ while empty.
  - Required: contents unchanged, OVERFLOW=1; COUNT stays 0, UNDERFLOW=1. Both flags hold until RST.
- Simultaneous ENQ+DEQ at COUNT=2
  - Required: COUNT stays 2; the head advances and the new entry is appended at the tail.
- Registered mode (BYPASS=0)
  - Stimulus: ENQ 0x3C on an empty FIFO.
  - Required: NOT_EMPTY=0 that cycle; next cycle NOT_EMPTY=1, DEQ_VALUE=0x3C.
- Consumed
  - Stimulus: ENQ in cycle 0, then nothing.
  - Required: CONSUMED=1 in cycle 0; CONSUMED_BEFORE=1 from cycle 1.
  - Stimulus: RESET and ENQ together in cycle 2.
  - Required: CONSUMED=1 in cycle 2; CONSUMED_BEFORE=0 in cycle 3.
